// File: rtl/miriscv_lsu_split_if.sv
// -----------------------------------------------------------------------------
// miriscv_lsu_split_if
// Data-bus bundle between the load/store unit and memory.
//   master modport (LSU side):
//     data_req   out  bus request
//     data_we    out  write enable
//     data_be    out  byte enables
//     data_addr  out  word-aligned byte address
//     data_wdata out  lane-shifted write data
//     data_gnt   in   grant for the current request
//     data_rvalid in  response valid (loads and stores)
//     data_rdata in   read data
//   slave modport (memory side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface miriscv_lsu_split_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              data_req;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  logic              data_we;
  logic [3:0]        data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/miriscv_lsu_split.sv
// -----------------------------------------------------------------------------
// miriscv_lsu_split
// Load/store unit between a single-cycle core and a req/gnt/rvalid data bus.
// One core access at a time; the core is stalled while it runs. Misaligned
// accesses that straddle a word are either split into two word beats or
// reported as errors. An optional timeout aborts a stuck REQ/WAIT state.
//
// Ports:
//   clk_i, resetn_i        clock, synchronous active-low reset
//   lsu_req_i              core access request, held until stall drops
//   lsu_we_i               1 = store, 0 = load
//   lsu_size_i             0 B, 1 H, 2 W, 4 BU, 5 HU (others illegal)
//   lsu_addr_i             byte address
//   lsu_data_i             right-aligned store data
//   lsu_stall_req_o        hold the core PC
//   lsu_data_o             extended load result (holds until the next load)
//   lsu_err_o              one-cycle error pulse
//   lsu_err_code_o         01 misaligned, 10 timeout, 11 illegal size
//   bus                    data bus (master side)
// -----------------------------------------------------------------------------
module miriscv_lsu_split #(
  parameter int unsigned ADDR_W        = 32,
  parameter bit          MISALIGNED_EN = 1'b1,
  parameter int unsigned TIMEOUT       = 0,
  parameter int unsigned TIMEOUT_W     = 8
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [2:0]          lsu_size_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [31:0]         lsu_data_i,
  output logic                lsu_stall_req_o,
  output logic [31:0]         lsu_data_o,
  output logic                lsu_err_o,
  output logic [1:0]          lsu_err_code_o,
  miriscv_lsu_split_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Last count value still inside the budget; the timeout fires on it.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  split_q;
  logic [31:0]           rd1_q, rd2_q;
  logic [1:0]            err_code_q, err_code_d;
  logic [TIMEOUT_W-1:0]  tcnt_q;
  logic [31:0]           load_q;

  // ---------------------------------------------------------------------------
  // Decode of the incoming request (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic in_legal, in_misal;

  always_comb begin
    in_legal = lsu_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    // Halfwords at offset 1/2 stay inside one word; only offset 3 straddles.
    in_misal = ((lsu_size_i[1:0] == 2'd1) && (lsu_addr_i[1:0] == 2'd3)) ||
               ((lsu_size_i[1:0] == 2'd2) && (lsu_addr_i[1:0] != 2'd0));
  end

  // ---------------------------------------------------------------------------
  // Lane alignment of the latched access. Shifting into a double-width
  // vector yields beat 1 in the low half and beat 2 in the high half.
  // ---------------------------------------------------------------------------
  logic [1:0]        off_q;
  logic [3:0]        size_mask;
  logic [7:0]        be_wide;
  logic [63:0]       wdata_wide;
  logic [ADDR_W-1:0] beat1_addr, beat2_addr;

  always_comb begin
    off_q = addr_q[1:0];
    unique case (size_q[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be_wide    = {4'b0000, size_mask} << off_q;
    wdata_wide = {32'h0, wdata_q} << {off_q, 3'b000};
    beat1_addr = {addr_q[ADDR_W-1:2], 2'b00};
    beat2_addr = beat1_addr + ADDR_W'(4);
  end

  // ---------------------------------------------------------------------------
  // Load result: the final beat's data is taken straight from the bus so the
  // result can be registered on the same edge that enters DONE.
  // ---------------------------------------------------------------------------
  logic [31:0] rd1_src, rd2_src, load_raw, load_ext;

  always_comb begin
    rd1_src  = (state_q == S_WAIT1) ? bus.data_rdata : rd1_q;
    rd2_src  = (state_q == S_WAIT2) ? bus.data_rdata : rd2_q;
    load_raw = 32'({rd2_src, rd1_src} >> {off_q, 3'b000});
    unique case (size_q)
      3'd0:    load_ext = {{24{load_raw[7]}},  load_raw[7:0]};
      3'd1:    load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
      3'd4:    load_ext = {24'h0, load_raw[7:0]};
      3'd5:    load_ext = {16'h0, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic. A handshake always takes priority over the timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (!in_legal) begin
            state_d    = S_ERR;
            err_code_d = ERR_SIZE;
          end else if (in_misal && !MISALIGNED_EN) begin
            state_d    = S_ERR;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d = S_REQ1;
          end
        end
      end
      S_REQ1: begin
        if (bus.data_gnt)     state_d = S_WAIT1;
        else if (timeout_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_WAIT1: begin
        if (bus.data_rvalid)  state_d = split_q ? S_REQ2 : S_DONE;
        else if (timeout_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_REQ2: begin
        if (bus.data_gnt)     state_d = S_WAIT2;
        else if (timeout_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_WAIT2: begin
        if (bus.data_rvalid)  state_d = S_DONE;
        else if (timeout_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: bus fields are only driven while requesting, zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    lsu_stall_req_o = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_we     = 1'b0;
    bus.data_be     = 4'b0000;
    bus.data_addr   = '0;
    bus.data_wdata  = 32'h0;
    unique case (state_q)
      S_IDLE:  lsu_stall_req_o = lsu_req_i;
      S_REQ1: begin
        lsu_stall_req_o = 1'b1;
        bus.data_req    = 1'b1;
        bus.data_we     = we_q;
        bus.data_be     = be_wide[3:0];
        bus.data_addr   = beat1_addr;
        bus.data_wdata  = wdata_wide[31:0];
      end
      S_REQ2: begin
        lsu_stall_req_o = 1'b1;
        bus.data_req    = 1'b1;
        bus.data_we     = we_q;
        bus.data_be     = be_wide[7:4];
        bus.data_addr   = beat2_addr;
        bus.data_wdata  = wdata_wide[63:32];
      end
      S_WAIT1, S_WAIT2: lsu_stall_req_o = 1'b1;
      default: lsu_stall_req_o = 1'b0;
    endcase
  end

  assign lsu_err_o      = (state_q == S_ERR);
  assign lsu_err_code_o = (state_q == S_ERR) ? err_code_q : 2'b00;
  assign lsu_data_o     = load_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      // NOTE: the design holds only a handful of control/data flops, so every
      // one of them is cleared; an aborted access leaves nothing behind.
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      wdata_q    <= 32'h0;
      split_q    <= 1'b0;
      rd1_q      <= 32'h0;
      rd2_q      <= 32'h0;
      err_code_q <= 2'b00;
      tcnt_q     <= '0;
      load_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;

      if ((state_q == S_IDLE) && lsu_req_i) begin
        addr_q  <= lsu_addr_i;
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        wdata_q <= lsu_data_i;
        split_q <= MISALIGNED_EN && in_misal;
      end

      if ((state_q == S_WAIT1) && bus.data_rvalid) rd1_q <= bus.data_rdata;
      if ((state_q == S_WAIT2) && bus.data_rvalid) rd2_q <= bus.data_rdata;

      // Only loads update the result; stores leave the previous value visible.
      if ((state_d == S_DONE) && (state_q != S_DONE) && !we_q) load_q <= load_ext;

      // Count restarts whenever a new state is entered.
      if (state_d != state_q)
        tcnt_q <= '0;
      else if (state_q inside {S_REQ1, S_WAIT1, S_REQ2, S_WAIT2})
        tcnt_q <= tcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// -----------------------------------------------------------------------------
// tb_miriscv_lsu_split
// Main DUT: MISALIGNED_EN=1, TIMEOUT=5, driven through an access task and a
// configurable bus responder. A byte-level transaction model predicts bus
// beats and load results; one negedge process compares against it.
// Second DUT: MISALIGNED_EN=0, TIMEOUT=0, used for the misaligned trap.
// -----------------------------------------------------------------------------
module tb_miriscv_lsu_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        lsu_req, lsu_we, stall, err;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  err_code;

  logic        b_req, b_we, b_stall, b_err;
  logic [2:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_code;

  miriscv_lsu_split_if #(.ADDR_W(32)) bus_a ();
  miriscv_lsu_split_if #(.ADDR_W(32)) bus_b ();

  miriscv_lsu_split #(.ADDR_W(32), .MISALIGNED_EN(1'b1), .TIMEOUT(5), .TIMEOUT_W(8)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata),
    .lsu_stall_req_o(stall), .lsu_data_o(lsu_rdata),
    .lsu_err_o(err), .lsu_err_code_o(err_code),
    .bus(bus_a.master)
  );

  miriscv_lsu_split #(.ADDR_W(32), .MISALIGNED_EN(1'b0), .TIMEOUT(0), .TIMEOUT_W(8)) dut_b (
    .clk_i(clk), .resetn_i(resetn),
    .lsu_req_i(b_req), .lsu_we_i(b_we), .lsu_size_i(b_size),
    .lsu_addr_i(b_addr), .lsu_data_i(b_wdata),
    .lsu_stall_req_o(b_stall), .lsu_data_o(b_rdata),
    .lsu_err_o(b_err), .lsu_err_code_o(b_code),
    .bus(bus_b.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] data;
  } done_t;

  beat_t       exp_beats[$];
  done_t       exp_done[$];
  logic [31:0] model_data = 32'h0;   // value lsu_data_o must currently show

  // Byte-by-byte view: each accessed byte lives in the first or next word.
  function automatic void model_push(input logic we, input logic [2:0] size,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rd1, input logic [31:0] rd2,
                                     input int gnt_dly);
    int          n, lane, idx;
    logic [29:0] first_w;
    logic [31:0] a, val, word;
    beat_t       b[2];
    bit          two;
    done_t       d;
    if (!(size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      d = '{is_err: 1'b1, code: 2'b11, data: model_data};
      exp_done.push_back(d);
      return;
    end
    n       = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    first_w = addr[31:2];
    b[0]    = '{addr: {first_w, 2'b00}, be: 4'b0, wdata: 32'h0, we: we};
    b[1]    = '{addr: {first_w + 30'd1, 2'b00}, be: 4'b0, wdata: 32'h0, we: we};
    val     = 32'h0;
    two     = 1'b0;
    for (int k = 0; k < n; k++) begin
      a    = addr + 32'(k);
      idx  = (a[31:2] == first_w) ? 0 : 1;
      lane = int'(a[1:0]);
      if (idx == 1) two = 1'b1;
      b[idx].be[lane]           = 1'b1;
      b[idx].wdata[8*lane +: 8] = wdata[8*k +: 8];
      word                      = (idx == 1) ? rd2 : rd1;
      val[8*k +: 8]             = word[8*lane +: 8];
    end
    if (size == 3'd0) val = {{24{val[7]}}, val[7:0]};
    if (size == 3'd1) val = {{16{val[15]}}, val[15:0]};
    exp_beats.push_back(b[0]);
    if (gnt_dly >= 5) begin
      d = '{is_err: 1'b1, code: 2'b10, data: model_data};
      exp_done.push_back(d);
      return;
    end
    if (two) exp_beats.push_back(b[1]);
    if (!we) model_data = val;
    d = '{is_err: 1'b0, code: 2'b00, data: model_data};
    exp_done.push_back(d);
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process (main DUT)
  // ---------------------------------------------------------------------------
  bit          cmp_en = 1'b0;
  bit          done_seen;
  int          req_cycles;
  int          obs_n;
  beat_t       obs[2];
  beat_t       eb;
  done_t       ed;
  logic [31:0] wmask;

  always @(negedge clk) begin
    if (cmp_en && resetn) begin
      if (bus_a.data_req) begin
        req_cycles++;
        if (exp_beats.size() == 0) begin
          check("req_without_beat", 32'(bus_a.data_req), 32'h0);
        end else begin
          eb    = exp_beats[0];
          wmask = {{8{eb.be[3]}}, {8{eb.be[2]}}, {8{eb.be[1]}}, {8{eb.be[0]}}};
          check("beat_addr",  bus_a.data_addr, eb.addr);
          check("beat_be",    32'(bus_a.data_be), 32'(eb.be));
          check("beat_we",    32'(bus_a.data_we), 32'(eb.we));
          check("beat_wdata", bus_a.data_wdata & wmask, eb.wdata);
          if (bus_a.data_gnt) begin
            if (obs_n < 2) obs[obs_n] = '{addr: bus_a.data_addr, be: bus_a.data_be,
                                          wdata: bus_a.data_wdata, we: bus_a.data_we};
            obs_n++;
            void'(exp_beats.pop_front());
          end
        end
      end
      if (lsu_req && !stall) begin
        if (exp_done.size() == 0) begin
          check("done_without_request", 32'(stall), 32'h1);
        end else begin
          ed = exp_done.pop_front();
          check("err_flag",  32'(err), 32'(ed.is_err));
          check("err_code",  32'(err_code), 32'(ed.code));
          check("load_data", lsu_rdata, ed.data);
          if (!ed.is_err) check("beats_left", 32'(exp_beats.size()), 32'h0);
          exp_beats.delete();
          done_seen = 1'b1;
        end
      end else begin
        check("err_idle",  32'(err), 32'h0);
        check("code_idle", 32'(err_code), 32'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus responder (main DUT): grant after gnt_cfg request cycles, rvalid
  // rv_cfg cycles after the grant, beat data from rd1_cfg/rd2_cfg.
  // ---------------------------------------------------------------------------
  bit          resp_en = 1'b1;
  int          gnt_cfg, rv_cfg, beat_idx;
  logic [31:0] rd1_cfg, rd2_cfg;

  initial begin
    int req_age, rv_age;
    bit pending;
    req_age = 0; rv_age = 0; pending = 1'b0;
    bus_a.data_gnt    = 1'b0;
    bus_a.data_rvalid = 1'b0;
    bus_a.data_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        bus_a.data_gnt    = 1'b0;
        bus_a.data_rvalid = 1'b0;
        bus_a.data_rdata  = 32'h5A5A5A5A;
        if (pending) begin
          if (rv_age == rv_cfg) begin
            bus_a.data_rvalid = 1'b1;
            bus_a.data_rdata  = (beat_idx == 0) ? rd1_cfg : rd2_cfg;
            beat_idx++;
            pending = 1'b0;
          end else begin
            rv_age++;
          end
        end else if (bus_a.data_req) begin
          if (req_age == gnt_cfg) begin
            bus_a.data_gnt = 1'b1;
            pending = 1'b1;
            rv_age  = 0;
            req_age = 0;
          end else begin
            req_age++;
          end
        end else begin
          req_age = 0;
        end
      end else begin
        req_age = 0;
        pending = 1'b0;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the cycle after completion.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd1, input logic [31:0] rd2,
                        input int gnt_dly, input int rv_dly, output int cycles);
    model_push(we, size, addr, wdata, rd1, rd2, gnt_dly);
    gnt_cfg = gnt_dly; rv_cfg = rv_dly; rd1_cfg = rd1; rd2_cfg = rd2;
    beat_idx = 0; obs_n = 0; req_cycles = 0; done_seen = 1'b0;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
    cycles = 0;
    while (!done_seen && cycles < 200) begin
      @(negedge clk); #1;
      cycles++;
    end
    check("access_complete", 32'(done_seen), 32'h1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    bit b_done;
    resetn = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_size = 3'd0; b_addr = 32'h0; b_wdata = 32'h0;
    bus_b.data_gnt = 1'b0; bus_b.data_rvalid = 1'b0; bus_b.data_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lsu_data", lsu_rdata, 32'h0);
    check("rst_err",      32'(err), 32'h0);
    check("rst_code",     32'(err_code), 32'h0);
    check("rst_req",      32'(bus_a.data_req), 32'h0);
    check("rst_we",       32'(bus_a.data_we), 32'h0);
    check("rst_be",       32'(bus_a.data_be), 32'h0);
    check("rst_addr",     bus_a.data_addr, 32'h0);
    check("rst_wdata",    bus_a.data_wdata, 32'h0);
    check("rst_stall",    32'(stall), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Aligned LW, grant after 2 cycles
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 2, 0, cyc);
    check("lw_addr",  obs[0].addr, 32'h100);
    check("lw_be",    32'(obs[0].be), 32'hF);
    check("lw_data",  lsu_rdata, 32'hDEADBEEF);
    check("lw_reqcyc", 32'(req_cycles), 32'd3);

    // Minimum aligned latency: IDLE, REQ1, WAIT1, DONE
    access(1'b0, 3'd2, 32'h104, 32'h0, 32'h01020304, 32'h0, 0, 0, cyc);
    check("lw_min_cycles", 32'(cyc), 32'd4);

    // LB / LBU at offset 3
    access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80112233, 32'h0, 1, 1, cyc);
    check("lb_be",   32'(obs[0].be), 32'h8);
    check("lb_data", lsu_rdata, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80112233, 32'h0, 0, 0, cyc);
    check("lbu_data", lsu_rdata, 32'h00000080);

    // Split SW; lsu_data_o keeps the last load value
    access(1'b1, 3'd2, 32'h301, 32'h11223344, 32'h0, 32'h0, 0, 1, cyc);
    check("sw_beats",  32'(obs_n), 32'd2);
    check("sw_b1_addr", obs[0].addr, 32'h300);
    check("sw_b1_be",   32'(obs[0].be), 32'hE);
    check("sw_b1_wd",   obs[0].wdata, 32'h22334400);
    check("sw_b2_addr", obs[1].addr, 32'h304);
    check("sw_b2_be",   32'(obs[1].be), 32'h1);
    check("sw_b2_wd",   obs[1].wdata, 32'h00000011);
    check("sw_keeps_data", lsu_rdata, 32'h00000080);

    // Split LW
    access(1'b0, 3'd2, 32'h302, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 0, cyc);
    check("lw_split_data", lsu_rdata, 32'h3344AABB);

    // Halfwords: split signed at offset 3, unsplit unsigned at offset 1
    access(1'b0, 3'd1, 32'h203, 32'h0, 32'hAB000000, 32'h000000CD, 0, 0, cyc);
    check("lh_split_data", lsu_rdata, 32'hFFFFCDAB);
    access(1'b0, 3'd5, 32'h201, 32'h0, 32'h12345678, 32'h0, 0, 0, cyc);
    check("lhu_data", lsu_rdata, 32'h00003456);
    check("lhu_beats", 32'(obs_n), 32'd1);

    // SH at offset 3, SB at offset 2
    access(1'b1, 3'd1, 32'h303, 32'h0000BEEF, 32'h0, 32'h0, 0, 0, cyc);
    check("sh_b1_wd", obs[0].wdata, 32'hEF000000);
    check("sh_b2_wd", obs[1].wdata, 32'h000000BE);
    access(1'b1, 3'd0, 32'h002, 32'h123456A5, 32'h0, 32'h0, 0, 0, cyc);
    check("sb_be", 32'(obs[0].be), 32'h4);

    // Address wrap on the second beat
    access(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 0, cyc);
    check("wrap_b2_addr", obs[1].addr, 32'h0);
    check("wrap_data", lsu_rdata, 32'hCCDD1122);

    // Timeout: grant never comes
    access(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 32'h0, 1000, 0, cyc);
    check("to_reqcyc", 32'(req_cycles), 32'd5);
    check("to_data_kept", lsu_rdata, 32'hCCDD1122);

    // Illegal sizes
    access(1'b0, 3'd3, 32'h600, 32'h0, 32'h0, 32'h0, 0, 0, cyc);
    check("size3_beats", 32'(obs_n), 32'd0);
    access(1'b1, 3'd7, 32'h600, 32'h0, 32'h0, 32'h0, 0, 0, cyc);

    // Back to normal after the error paths
    access(1'b0, 3'd4, 32'h701, 32'h0, 32'h0000C300, 32'h0, 0, 2, cyc);
    check("post_err_lbu", lsu_rdata, 32'h000000C3);

    // Reset in WAIT1: access abandoned, later rvalid ignored
    cmp_en = 1'b0; resp_en = 1'b0;
    bus_a.data_gnt = 1'b0; bus_a.data_rvalid = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h400;
    @(posedge clk); #1;
    bus_a.data_gnt = 1'b1;
    @(posedge clk); #1;
    bus_a.data_gnt = 1'b0;
    check("wait1_stall", 32'(stall), 32'h1);
    resetn = 1'b0; lsu_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    bus_a.data_rvalid = 1'b1; bus_a.data_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_mid_data",  lsu_rdata, 32'h0);
    check("rst_mid_req",   32'(bus_a.data_req), 32'h0);
    check("rst_mid_stall", 32'(stall), 32'h0);
    check("rst_mid_err",   32'(err), 32'h0);
    @(posedge clk); #1;
    bus_a.data_rvalid = 1'b0;
    @(negedge clk);
    check("rst_rvalid_ignored", lsu_rdata, 32'h0);
    check("rst_rvalid_noerr",   32'(err), 32'h0);
    @(posedge clk); #1;
    model_data = 32'h0;
    exp_beats.delete(); exp_done.delete();
    resp_en = 1'b1; cmp_en = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 3'd1, 32'h802, 32'h0, 32'h7FFF0000, 32'h0, 0, 0, cyc);
    check("post_rst_lh", lsu_rdata, 32'h00007FFF);

    // Trap variant: misaligned LW gives an error with no bus activity
    b_req = 1'b1; b_we = 1'b0; b_size = 3'd2; b_addr = 32'h302;
    b_done = 1'b0; cyc = 0;
    while (!b_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      check("trap_no_req", 32'(bus_b.data_req), 32'h0);
      if (b_req && !b_stall) begin
        b_done = 1'b1;
        check("trap_err",  32'(b_err), 32'h1);
        check("trap_code", 32'(b_code), 32'h1);
      end
    end
    check("trap_done", 32'(b_done), 32'h1);
    check("trap_cycles", 32'(cyc), 32'd2);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check("trap_err_clear",  32'(b_err), 32'h0);
    check("trap_code_clear", 32'(b_code), 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu_split.md
Name: miriscv_lsu_split

Overview:
Parametrised next-generation load/store unit between the single-cycle core datapath and the data bus. It accepts one load/store per core request and holds the core with a stall while the access runs. It performs a request/grant/rvalid bus handshake and byte-lane alignment with sign/zero extension. Unlike the previous LSU, it splits misaligned accesses into two word beats, optionally traps them instead, and has an optional bus timeout with error reporting.

Parameters:
ADDR_W, 32, width of lsu_addr_i and data_addr_o
MISALIGNED_EN, 1, 1 = split misaligned accesses into two beats; 0 = report a misaligned error with no bus access
TIMEOUT, 0, maximum cycles to wait in a request or wait state before a timeout error; 0 disables the timeout
TIMEOUT_W, 8, width of the timeout counter; TIMEOUT < 2**TIMEOUT_W

Ports:
clk_i  in  1  clock, rising edge
resetn_i  in  1  synchronous active-low reset
lsu_req_i  in  1  core requests a memory access; held high until the stall drops
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; 3, 6 and 7 are illegal
lsu_addr_i  in  ADDR_W  byte address
lsu_data_i  in  32  store data, right-aligned
lsu_stall_req_o  out  1  hold the core's PC
lsu_data_o  out  32  extended load result
lsu_err_o  out  1  one-cycle error pulse
lsu_err_code_o  out  2  01 misaligned, 10 timeout, 11 illegal size
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  response valid; applies to both loads and stores
data_rdata_i  in  32  read data
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_addr_o  out  ADDR_W  word-aligned bus address (bits [1:0] = 0)
data_wdata_o  out  32  lane-shifted write data

Behaviour:
- Reset: synchronous. If resetn_i = 0 at a rising edge, the state goes to IDLE and all registers clear. lsu_data_o, lsu_err_o, lsu_err_code_o, data_req_o, data_we_o, data_be_o, data_addr_o and data_wdata_o are all 0. Reset mid-access abandons the access; no completion or error is reported.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, ERR.
- Stall: lsu_stall_req_o = lsu_req_i in IDLE; 1 in REQ1/WAIT1/REQ2/WAIT2; 0 in DONE and ERR.
- IDLE with lsu_req_i = 1: latch address, we, size and data; let o = addr[1:0].
  - Illegal size -> ERR, code 11.
  - Misaligned (LH/LHU/SH with o = 3; LW/SW with o != 0):
    - MISALIGNED_EN = 0 -> ERR, code 01.
    - MISALIGNED_EN = 1 -> REQ1 with a split flag set.
  - Otherwise -> REQ1.
  - Misaligned halfword cases: o = 1 or 2 fit in one word; only o = 3 splits.
- REQ1/REQ2: data_req_o = 1 with stable addr/we/be/wdata until data_gnt_i. On grant, go to WAIT1/WAIT2 and data_req_o drops on the next cycle.
- WAIT1:
  - On data_rvalid_i, capture data_rdata_i into rd1.
  - If split -> REQ2, else -> DONE.
  - data_rvalid_i outside WAIT1/WAIT2 is ignored.
- WAIT2: on data_rvalid_i, capture rd2 and go to DONE.
- Beat 1: address = {addr[ADDR_W-1:2], 2'b00}.
  - be = (size mask << o) & 4'hF, where the size mask is 0001, 0011 or 1111.
  - wdata = lsu_data_i << 8*o.
- Beat 2: address = beat-1 address + 4, with natural wrap at 2**ADDR_W.
  - be = size mask >> (4 - o).
  - wdata = lsu_data_i >> 8*(4 - o).
- Store bytes/halfwords replicate nothing; lanes outside be are don't-care but driven as shifted.
- DONE: for one cycle, lsu_data_o = extended value of ({rd2, rd1} >> 8*o) truncated to the access size.
  - Sign extension for LB/LH; zero extension for LBU/LHU.
  - Stores leave lsu_data_o unchanged.
  - Next state is IDLE.
- ERR: lsu_err_o = 1 and lsu_err_code_o is valid for one cycle; next state is IDLE. lsu_err_code_o returns to 0 in IDLE.
- Timeout (TIMEOUT > 0):
  - The counter clears on entry to each REQ/WAIT state and increments every cycle spent there.
  - When the count reaches TIMEOUT without the exiting handshake, go to ERR with code 10 and deassert data_req_o.
  - A handshake arriving in the same cycle as the timeout wins.
- Back-to-back: the IDLE cycle after DONE/ERR samples lsu_req_i afresh, so the minimum aligned access costs 4 cycles: IDLE, REQ1, WAIT1, DONE.
- Grant and rvalid in the same cycle while in REQ: rvalid is ignored. Responses are accepted only in WAIT states.

Test Plan:
- Aligned LW at 0x100, gnt after 2 cycles, rvalid 1 cycle later, rdata 0xDEADBEEF -> addr 0x100, be 1111, stall high until DONE, lsu_data_o 0xDEADBEEF for one cycle.
- LB at 0x203 with rdata 0x80112233 -> be 1000, lsu_data_o 0xFFFFFF80; LBU at the same address gives 0x00000080.
- MISALIGNED_EN=1, SW 0x11223344 at 0x301:
  - Beat 1: addr 0x300, be 1110, wdata 0x22334400.
  - Beat 2: addr 0x304, be 0001, wdata 0x00000011.
  - Stall drops only after the second rvalid.
- MISALIGNED_EN=1, LW at 0x302 with rd1 0xAABBCCDD and rd2 0x11223344 -> lsu_data_o 0x3344AABB. With MISALIGNED_EN=0, the same LW gives no data_req_o, lsu_err_o pulse and code 01.
- TIMEOUT=5, gnt never asserted -> data_req_o for 5 cycles, then err code 10, then IDLE.
- Size 3 -> err code 11. resetn_i=0 during WAIT1 -> IDLE with outputs 0, and a following rvalid is ignored.
